dht11_read_ctrl: RTL and testbench
==================================

Name: dht11_read_ctrl

Overview:
- Sequences one complete DHT11 single-wire read: host start pulse, sensor response handshake, 40-bit data capture, checksum check.
- Sits between the raw open-drain DQ pad (via tri-state buffer: pad driven low when dq_oe=1, otherwise pulled up) and the display/UART consumer of humidity and temperature bytes.
- Contains its own 2-flop input synchronizer and microsecond timebase.

Parameters:
- CLK_PER_US, 100, clk cycles per microsecond (prescaler terminal count).
- T_START_US, 18000, host start-low duration, us.
- T_TO_US, 100, per-phase timeout, us.
- T_BIT_THR_US, 50, high-time threshold, us; a high time greater than this decodes as 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset is synchronous and active-low (rst=0 resets on the clk rising edge).
- en_set  in  1  read request, sampled in IDLE only.
- dq_in  in  1  raw DQ pad level, asynchronous.
- dq_oe  out  1  1 = drive DQ low, 0 = release.
- busy  out  1  high from the cycle after request acceptance until return to IDLE.
- done  out  1  1-cycle pulse when a frame is received and the checksum passes.
- err  out  1  1-cycle pulse on a timeout or checksum failure.
- err_code  out  3  0 none, 1 no response, 2 response-phase timeout, 3 bit-phase timeout, 4 checksum mismatch; held until the next accepted request.
- hum_int, hum_dec, temp_int, temp_dec  out  8 each  last valid frame bytes.
- chk_ok  out  1  1 if the last completed frame passed its checksum.

Behaviour:
- Reset: all outputs 0. dq_oe=0, so the line is released. FSM goes to IDLE and the shift register, counters and synchronizer clear. Reset mid-read aborts immediately, with no done/err pulse.
- Synchronizer: two flops plus one history flop. Edges are detected on the synchronized value, so pad-to-edge latency is 3 cycles.
- Timebase:
  - Prescaler produces us_tick every CLK_PER_US cycles.
  - us_cnt is 15 bits and increments on us_tick, saturating at 32767.
  - Prescaler and us_cnt both clear on every state entry.
- FSM states and transitions:
  - IDLE: dq_oe=0, busy=0. When en_set=1, clear bit index and err_code, then go to START_LOW. en_set while busy is ignored and not queued. Inter-read spacing (at least 1 s) is the requester's responsibility.
  - START_LOW: dq_oe=1. When us_cnt==T_START_US, go to WAIT_RESP with dq_oe=0. Low time is exactly T_START_US*CLK_PER_US cycles, ±1.
  - WAIT_RESP: falling edge -> RESP_LOW. If us_cnt==T_TO_US first, error with code 1. A falling edge is required, so the host's own low phase is never mistaken for a response.
  - RESP_LOW: rising edge -> RESP_HIGH. Timeout -> code 2.
  - RESP_HIGH: falling edge -> BIT_LOW. Timeout -> code 2.
  - BIT_LOW: rising edge -> BIT_HIGH. Timeout -> code 3.
  - BIT_HIGH: on a falling edge, shift in (us_cnt > T_BIT_THR_US) MSB-first and increment the bit index. If the index was 39, go to FINISH; otherwise go to BIT_LOW. Timeout -> code 3.
  - FINISH (1 cycle): checksum = (b4+b3+b2+b1) mod 256 compared with b0.
    - Match: load the four data bytes, set chk_ok=1, pulse done.
    - Mismatch: data bytes keep their previous values, set chk_ok=0, err pulse with code 4.
    - Go to IDLE.
  - Error exit (any state): err pulse for 1 cycle, dq_oe=0, go to IDLE the next cycle.
- Edge and timeout in the same cycle: the edge wins.
- done and err are never asserted together.
- Total cycles from accept to done are deterministic given the sensor waveform.

Test Plan:
- Reset: rst=0 for 3 cycles while en_set=1 and dq_in toggles -> dq_oe=0, busy=0, all data outputs 0x00, err_code=0.
- Nominal read with CLK_PER_US=4, T_START_US=40, sensor model sending 0x35,0x00,0x18,0x00,0x4D -> dq_oe high for 160±1 cycles, then one done pulse with hum_int=0x35, temp_int=0x18, hum_dec=temp_dec=0, chk_ok=1.
- Checksum fault: same frame with last byte 0x4C -> one err pulse, err_code=4, chk_ok=0, data outputs still 0x35/0x18 from the prior read.
- No response: line held high after release -> err at T_TO_US us after release (±1 us), err_code=1, busy drops the next cycle.
- Bit decode and stall:
  - High times of 26 us decode as 0 and 70 us as 1; 50 us decodes as 0 and 51 us as 1.
  - Line stuck high during bit 12 -> err_code=3.
- Overlap/abort:
  - en_set pulsed during BIT_LOW -> ignored, frame completes normally.
  - rst=0 during BIT_HIGH -> dq_oe=0 and busy=0 from that edge, with no done/err pulse.

Source files
------------

// File: rtl/dht11_read_ctrl_if.sv
// Request/result bundle between the DHT11 read controller and its consumer
// (display or UART side): read request in, status pulses and frame bytes out.
interface dht11_read_ctrl_if;
   logic       en_set;
   logic       busy;
   logic       done;
   logic       err;
   logic [2:0] err_code;
   logic [7:0] hum_int;
   logic [7:0] hum_dec;
   logic [7:0] temp_int;
   logic [7:0] temp_dec;
   logic       chk_ok;

   modport master (
      output en_set,
      input  busy, done, err, err_code,
      input  hum_int, hum_dec, temp_int, temp_dec, chk_ok
   );

   modport slave (
      input  en_set,
      output busy, done, err, err_code,
      output hum_int, hum_dec, temp_int, temp_dec, chk_ok
   );
endinterface

// File: rtl/dht11_read_ctrl.sv
// DHT11 single-wire read sequencer: start pulse, response handshake, 40-bit
// capture and checksum, with its own pad synchronizer and microsecond timebase.
module dht11_read_ctrl #(
   parameter int CLK_PER_US   = 100,
   parameter int T_START_US   = 18000,
   parameter int T_TO_US      = 100,
   parameter int T_BIT_THR_US = 50
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dq_in,
   output logic             dq_oe,
   dht11_read_ctrl_if.slave bus
);

   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);
   localparam logic [14:0]   START_CNT  = 15'(T_START_US);
   localparam logic [14:0]   TO_CNT     = 15'(T_TO_US);
   localparam logic [14:0]   THR_CNT    = 15'(T_BIT_THR_US);
   localparam logic [14:0]   CNT_MAX    = 15'h7FFF;

   typedef enum logic [3:0] {
      IDLE,
      START_LOW,
      WAIT_RESP,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      FINISH,
      FAULT
   } state_t;

   state_t        state_reg, state_next;

   logic          sync1_reg, sync2_reg, hist_reg;
   logic          rise, fall;

   logic [PW-1:0] presc_reg, presc_next;
   logic          us_tick;
   logic [14:0]   us_cnt_reg, us_cnt_inc, us_cnt_next;
   logic          entry;
   logic          timeout;

   logic [38:0]   shift_reg;
   logic [39:0]   frame_next;
   logic [5:0]    idx_reg;
   logic          bit_val;
   logic [7:0]    frame_byte [5];
   logic [7:0]    sum_calc;
   logic          sum_ok;

   logic          accept;
   logic          take_bit;
   logic          last_bit;
   logic [2:0]    fault_code;

   logic          done_reg, err_reg, chk_ok_reg;
   logic [2:0]    err_code_reg;
   logic [7:0]    hum_int_reg, hum_dec_reg, temp_int_reg, temp_dec_reg;

   // Edges come from the synchronized level against a one-cycle history.
   assign rise = sync2_reg & ~hist_reg;
   assign fall = ~sync2_reg & hist_reg;

   assign us_tick    = (presc_reg == PRESC_LAST);
   assign presc_next = us_tick ? '0 : presc_reg + 1'b1;
   assign us_cnt_inc = (us_tick && us_cnt_reg != CNT_MAX) ? us_cnt_reg + 15'd1 : us_cnt_reg;
   assign entry      = (state_next != state_reg);
   assign us_cnt_next = entry ? 15'd0 : us_cnt_inc;
   assign timeout    = (us_cnt_reg == TO_CNT);

   // The falling edge lands on the last cycle of the high phase, so the count
   // including this cycle's tick is the full high time in microseconds.
   assign bit_val    = (us_cnt_inc > THR_CNT);
   assign frame_next = {shift_reg, bit_val};
   assign last_bit   = (idx_reg == 6'd39);

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_byte
         assign frame_byte[gi] = frame_next[8*gi +: 8];
      end
   endgenerate

   assign sum_calc = frame_byte[4] + frame_byte[3] + frame_byte[2] + frame_byte[1];
   assign sum_ok   = (sum_calc == frame_byte[0]);

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      take_bit   = 1'b0;
      fault_code = 3'd0;
      dq_oe      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.en_set) begin
               accept     = 1'b1;
               state_next = START_LOW;
            end
         end
         START_LOW: begin
            if (us_cnt_reg == START_CNT) begin
               state_next = WAIT_RESP;
            end else begin
               dq_oe = 1'b1;
            end
         end
         WAIT_RESP: begin
            if (fall) begin
               state_next = RESP_LOW;
            end else if (timeout) begin
               state_next = FAULT;
               fault_code = 3'd1;
            end
         end
         RESP_LOW: begin
            if (rise) begin
               state_next = RESP_HIGH;
            end else if (timeout) begin
               state_next = FAULT;
               fault_code = 3'd2;
            end
         end
         RESP_HIGH: begin
            if (fall) begin
               state_next = BIT_LOW;
            end else if (timeout) begin
               state_next = FAULT;
               fault_code = 3'd2;
            end
         end
         BIT_LOW: begin
            if (rise) begin
               state_next = BIT_HIGH;
            end else if (timeout) begin
               state_next = FAULT;
               fault_code = 3'd3;
            end
         end
         BIT_HIGH: begin
            if (fall) begin
               take_bit   = 1'b1;
               state_next = last_bit ? FINISH : BIT_LOW;
            end else if (timeout) begin
               state_next = FAULT;
               fault_code = 3'd3;
            end
         end
         FINISH:  state_next = IDLE;
         FAULT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Result registers load on entry to FINISH/FAULT so the pulse, its code
   // and the frame bytes all appear together while busy is still high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         sync1_reg    <= 1'b0;
         sync2_reg    <= 1'b0;
         hist_reg     <= 1'b0;
         presc_reg    <= '0;
         us_cnt_reg   <= 15'd0;
         shift_reg    <= 39'd0;
         idx_reg      <= 6'd0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         err_code_reg <= 3'd0;
         chk_ok_reg   <= 1'b0;
         hum_int_reg  <= 8'd0;
         hum_dec_reg  <= 8'd0;
         temp_int_reg <= 8'd0;
         temp_dec_reg <= 8'd0;
      end else begin
         state_reg  <= state_next;
         sync1_reg  <= dq_in;
         sync2_reg  <= sync1_reg;
         hist_reg   <= sync2_reg;
         presc_reg  <= entry ? '0 : presc_next;
         us_cnt_reg <= us_cnt_next;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;

         if (accept) begin
            idx_reg      <= 6'd0;
            shift_reg    <= 39'd0;
            err_code_reg <= 3'd0;
         end

         if (take_bit) begin
            shift_reg <= frame_next[38:0];
            idx_reg   <= idx_reg + 6'd1;
            if (last_bit) begin
               if (sum_ok) begin
                  hum_int_reg  <= frame_byte[4];
                  hum_dec_reg  <= frame_byte[3];
                  temp_int_reg <= frame_byte[2];
                  temp_dec_reg <= frame_byte[1];
                  chk_ok_reg   <= 1'b1;
                  done_reg     <= 1'b1;
               end else begin
                  chk_ok_reg   <= 1'b0;
                  err_reg      <= 1'b1;
                  err_code_reg <= 3'd4;
               end
            end
         end

         if (fault_code != 3'd0) begin
            err_reg      <= 1'b1;
            err_code_reg <= fault_code;
         end
      end
   end

   assign bus.busy     = (state_reg != IDLE);
   assign bus.done     = done_reg;
   assign bus.err      = err_reg;
   assign bus.err_code = err_code_reg;
   assign bus.chk_ok   = chk_ok_reg;
   assign bus.hum_int  = hum_int_reg;
   assign bus.hum_dec  = hum_dec_reg;
   assign bus.temp_int = temp_int_reg;
   assign bus.temp_dec = temp_dec_reg;

endmodule

// File: tb/tb_dht11_read_ctrl.sv
// Bench for dht11_read_ctrl: an open-drain sensor model drives DQ, expected
// results are queued per request and matched against each done/err pulse.
module tb_dht11_read_ctrl;

   localparam int CPU     = 4;
   localparam int T_START = 40;
   localparam int T_TO    = 100;
   localparam int T_THR   = 50;

   typedef struct {
      logic       is_done;
      logic [2:0] code;
      logic [7:0] hi;
      logic [7:0] hd;
      logic [7:0] ti;
      logic [7:0] td;
      logic       chk;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sensor_lvl = 1'b1;
   logic dq_in;
   logic dq_oe;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   logic [7:0] m_hi = 8'd0, m_hd = 8'd0, m_ti = 8'd0, m_td = 8'd0;
   logic       m_chk = 1'b0;

   dht11_read_ctrl_if bus ();

   dht11_read_ctrl #(
      .CLK_PER_US   (CPU),
      .T_START_US   (T_START),
      .T_TO_US      (T_TO),
      .T_BIT_THR_US (T_THR)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .dq_in (dq_in),
      .dq_oe (dq_oe),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Open-drain pad: host pulls low, otherwise sensor level (pulled up).
   assign dq_in = (dq_oe === 1'b1) ? 1'b0 : sensor_lvl;

   // Scoreboard: every done/err pulse consumes one queued expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst === 1'b1 && (bus.done === 1'b1 || bus.err === 1'b1)) begin
         checks++;
         if (bus.done === 1'b1 && bus.err === 1'b1) begin
            errors++;
            $display("FAIL pulse_exclusive: done=%0b err=%0b, required not both", bus.done, bus.err);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: done=%0b err=%0b code=%0d, required no pulse",
                     bus.done, bus.err, bus.err_code);
         end else begin
            e = exp_q.pop_front();
            if (bus.done !== e.is_done || bus.err !== !e.is_done || bus.err_code !== e.code ||
                bus.hum_int !== e.hi || bus.hum_dec !== e.hd || bus.temp_int !== e.ti ||
                bus.temp_dec !== e.td || bus.chk_ok !== e.chk) begin
               errors++;
               $display("FAIL result: got done=%0b err=%0b code=%0d %h/%h/%h/%h chk=%0b, required done=%0b code=%0d %h/%h/%h/%h chk=%0b",
                        bus.done, bus.err, bus.err_code, bus.hum_int, bus.hum_dec, bus.temp_int,
                        bus.temp_dec, bus.chk_ok, e.is_done, e.code, e.hi, e.hd, e.ti, e.td, e.chk);
            end else begin
               $display("txn: done=%0b err=%0b code=%0d hum=%h.%h temp=%h.%h chk=%0b",
                        bus.done, bus.err, bus.err_code, bus.hum_int, bus.hum_dec,
                        bus.temp_int, bus.temp_dec, bus.chk_ok);
            end
         end
      end
   end

   task automatic expect_frame(input logic [39:0] f);
      exp_t       e;
      logic [7:0] s;
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      if (s == f[7:0]) begin
         m_hi = f[39:32]; m_hd = f[31:24]; m_ti = f[23:16]; m_td = f[15:8];
         m_chk = 1'b1;
         e.is_done = 1'b1; e.code = 3'd0;
      end else begin
         m_chk = 1'b0;
         e.is_done = 1'b0; e.code = 3'd4;
      end
      e.hi = m_hi; e.hd = m_hd; e.ti = m_ti; e.td = m_td; e.chk = m_chk;
      exp_q.push_back(e);
   endtask

   task automatic expect_fault(input logic [2:0] code);
      exp_t e;
      e.is_done = 1'b0; e.code = code;
      e.hi = m_hi; e.hd = m_hd; e.ti = m_ti; e.td = m_td; e.chk = m_chk;
      exp_q.push_back(e);
   endtask

   // All stimulus tasks start and end at posedge+1.
   task automatic hold(input logic v, input int us);
      sensor_lvl = v;
      repeat (us * CPU) @(posedge clk);
      #1;
   endtask

   task automatic request(output int low_cycles);
      int n;
      @(posedge clk); #1 bus.en_set = 1'b1;
      @(posedge clk); #1 bus.en_set = 1'b0;
      n = 0;
      while (dq_oe === 1'b1 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      low_cycles = n;
   endtask

   task automatic run_frame(input logic [39:0] frame, input int hi0, input int hi1,
                            input int stall_bit, input int pulse_bit, input int abort_bit,
                            output int low_cycles, output bit got_pulse, output bit aborted);
      int w;
      aborted   = 1'b0;
      got_pulse = 1'b0;
      request(low_cycles);
      hold(1'b1, 20);
      hold(1'b0, 80);
      hold(1'b1, 80);
      for (int i = 0; i < 40; i++) begin
         if (i == pulse_bit) begin
            sensor_lvl = 1'b0;
            @(posedge clk); #1 bus.en_set = 1'b1;
            @(posedge clk); #1 bus.en_set = 1'b0;
            hold(1'b0, 48);
         end else begin
            hold(1'b0, 50);
         end
         if (i == abort_bit) begin
            sensor_lvl = 1'b1;
            repeat (80) @(posedge clk);
            #1 rst = 1'b0;
            @(posedge clk); #1;
            aborted = 1'b1;
            return;
         end
         if (i == stall_bit) begin
            sensor_lvl = 1'b1;
            break;
         end
         hold(1'b1, frame[39-i] ? hi1 : hi0);
      end
      if (stall_bit >= 40) sensor_lvl = 1'b0;
      w = 0;
      while (!(bus.done === 1'b1 || bus.err === 1'b1) && w < 1000) begin
         @(posedge clk); #1;
         w++;
      end
      got_pulse = (w < 1000);
      repeat (100) @(posedge clk);
      #1 sensor_lvl = 1'b1;
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bus.en_set = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sensor_lvl = ~sensor_lvl;
         @(posedge clk); #1;
      end
      checks++;
      if (dq_oe !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: dq_oe=%0b busy=%0b done=%0b err=%0b, required all 0",
                  dq_oe, bus.busy, bus.done, bus.err);
      end
      checks++;
      if ({bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec} !== 32'h0 ||
          bus.err_code !== 3'd0 || bus.chk_ok !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: data=%h code=%0d chk=%0b, required 0/0/0",
                  {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec}, bus.err_code, bus.chk_ok);
      end
      bus.en_set = 1'b0;
      sensor_lvl = 1'b1;
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: busy=%0b, required 0", bus.busy);
      end
      $display("txn: reset done");
   endtask

   task automatic test_frame(input string name, input logic [39:0] frame,
                             input int hi0, input int hi1, input int stall_bit, input int pulse_bit);
      int low;
      bit got, ab;
      if (stall_bit < 40) expect_fault(3'd3);
      else expect_frame(frame);
      run_frame(frame, hi0, hi1, stall_bit, pulse_bit, 99, low, got, ab);
      checks++;
      if (low < T_START * CPU - 1 || low > T_START * CPU + 1) begin
         errors++;
         $display("FAIL %s start_low: %0d cycles, required %0d +-1", name, low, T_START * CPU);
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s pulse_timeout: no done/err seen, required one pulse", name);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s scoreboard: %0d pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_after: busy=%0b, required 0", name, bus.busy);
      end
   endtask

   task automatic test_nominal;
      test_frame("nominal", 40'h35_00_18_00_4D, 26, 70, 99, 99);
   endtask

   task automatic test_checksum;
      test_frame("checksum", 40'h35_00_18_00_4C, 26, 70, 99, 99);
      checks++;
      if (bus.err_code !== 3'd4 || bus.chk_ok !== 1'b0 || bus.hum_int !== 8'h35 || bus.temp_int !== 8'h18) begin
         errors++;
         $display("FAIL checksum_held: code=%0d chk=%0b hum=%h temp=%h, required 4/0/35/18",
                  bus.err_code, bus.chk_ok, bus.hum_int, bus.temp_int);
      end
   endtask

   task automatic test_no_response;
      int low, n;
      expect_fault(3'd1);
      request(low);
      n = 0;
      while (bus.err !== 1'b1 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n < (T_TO - 1) * CPU || n > (T_TO + 1) * CPU) begin
         errors++;
         $display("FAIL noresp_time: err after %0d cycles, required %0d +-%0d", n, T_TO * CPU, CPU);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL noresp_busy_at_err: busy=%0b, required 1", bus.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL noresp_busy_drop: busy=%0b err=%0b, required 0/0", bus.busy, bus.err);
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (bus.err_code !== 3'd1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL noresp_code: code=%0d pending=%0d, required 1/0", bus.err_code, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_bit_threshold;
      test_frame("threshold", 40'h12_34_56_78_14, 50, 51, 99, 99);
   endtask

   task automatic test_stall;
      test_frame("stall", 40'h35_00_18_00_4D, 26, 70, 12, 99);
      checks++;
      if (bus.err_code !== 3'd3 || bus.hum_int !== 8'h12 || bus.chk_ok !== 1'b1) begin
         errors++;
         $display("FAIL stall_code: code=%0d hum=%h chk=%0b, required 3/12/1",
                  bus.err_code, bus.hum_int, bus.chk_ok);
      end
   endtask

   task automatic test_overlap;
      int n;
      test_frame("overlap", 40'h40_01_1A_02_5D, 26, 70, 99, 5);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.busy === 1'b1) n++;
         @(posedge clk); #1;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL overlap_queued: busy for %0d cycles, required 0", n);
      end
   endtask

   task automatic test_abort;
      int low;
      bit got, ab;
      run_frame(40'h35_00_18_00_4D, 26, 70, 99, 99, 20, low, got, ab);
      checks++;
      if (!ab || dq_oe !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL abort_ctrl: aborted=%0b dq_oe=%0b busy=%0b done=%0b err=%0b, required 1/0/0/0/0",
                  ab, dq_oe, bus.busy, bus.done, bus.err);
      end
      checks++;
      if ({bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec} !== 32'h0 || bus.chk_ok !== 1'b0) begin
         errors++;
         $display("FAIL abort_data: data=%h chk=%0b, required 0/0",
                  {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec}, bus.chk_ok);
      end
      m_hi = 8'd0; m_hd = 8'd0; m_ti = 8'd0; m_td = 8'd0; m_chk = 1'b0;
      rst = 1'b1;
      sensor_lvl = 1'b1;
      repeat (600) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%0b, required 0", bus.busy);
      end
      $display("txn: abort during bit 20");
   endtask

   initial begin
      bus.en_set = 1'b0;
      test_reset();
      test_nominal();
      test_checksum();
      test_no_response();
      test_bit_threshold();
      test_stall();
      test_overlap();
      test_abort();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_scoreboard: %0d pending, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
